// File: rtl/jogo_desafio_memoria_top.sv
// jogo_desafio_memoria_top: Simon-style memory game with sequence RAM, round/address/timeout counters and control FSM.
// Rev 1.0
`default_nettype none

module jogo_desafio_memoria_top #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SHOW_CYCLES    = 500,
  parameter int GAP_CYCLES     = 250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic [1:0] configuracao,
  input  logic [3:0] botoes,
  output logic [3:0] leds,
  output logic [2:0] leds_rgb,
  output logic       ganhou,
  output logic       perdeu,
  output logic       timeout,
  output logic       pronto,
  output logic       db_igual,
  output logic       db_enderecoIgualLimite,
  output logic       db_timeout,
  output logic       db_escrita,
  output logic       db_clock,
  output logic       db_iniciar,
  output logic       db_modo,
  output logic       db_configuracao,
  output logic [6:0] db_contagem,
  output logic [6:0] db_memoria,
  output logic [6:0] db_estado,
  output logic [6:0] db_jogadafeita,
  output logic [6:0] db_limite_rodada
);

  typedef enum logic [4:0] {
    S_INICIAL        = 5'b00000,
    S_PREPARACAO     = 5'b00001,
    S_INICIA_RODADA  = 5'b00010,
    S_MOSTRA         = 5'b00011,
    S_INTERVALO      = 5'b00100,
    S_TESTA_EXIBICAO = 5'b00101,
    S_PREP_JOGADA    = 5'b00110,
    S_ESPERA_JOGADA  = 5'b00111,
    S_REGISTRA       = 5'b01000,
    S_PROXIMO_LED    = 5'b01001,
    S_COMPARA        = 5'b01010,
    S_FIM_RODADA     = 5'b01011,
    S_PROXIMA_JOGADA = 5'b01100,
    S_GANHOU         = 5'b01101,
    S_PERDEU         = 5'b01110,
    S_FIM_TIMEOUT    = 5'b01111,
    S_ESPERA_ESCRITA = 5'b10000,
    S_PROXIMA_RODADA = 5'b10001,
    S_ESCREVE        = 5'b10010
  } state_t;

  localparam int CW = $clog2((SHOW_CYCLES > GAP_CYCLES ? SHOW_CYCLES : GAP_CYCLES) + 1);
  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [12:0]   TMO_LAST  = 13'(TIMEOUT_CYCLES - 1);
  // Entry 0 sits in the least significant nibble.
  localparam logic [63:0] PRELOAD = {4'b0100, 4'b0001, 4'b1000, 4'b1000, 4'b0100, 4'b0100, 4'b0010, 4'b0010,
                                     4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};

  state_t          state_q, state_d;
  logic [3:0]      endereco_q, endereco_d;
  logic [3:0]      limite_q, limite_d;
  logic [12:0]     tempo_q, tempo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      jogada_q, jogada_d;
  logic            modo_q, modo_d;
  logic            escrita_q, escrita_d;
  logic            botao_q;
  logic [3:0]      mem_q [16];
  logic            we;

  logic [3:0] mem_rd;
  logic       igual, fim_ender, jogada, tmo_fim;

  assign mem_rd    = mem_q[endereco_q];
  assign igual     = (jogada_q == mem_rd);
  assign fim_ender = (endereco_q == limite_q);
  // Edge of the OR keeps a held button from counting twice or on entry to a wait state.
  assign jogada    = (|botoes) & ~botao_q;
  assign tmo_fim   = (tempo_q == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    endereco_d = endereco_q;
    limite_d   = limite_q;
    tempo_d    = tempo_q;
    cnt_d      = '0;
    jogada_d   = jogada_q;
    modo_d     = modo_q;
    escrita_d  = escrita_q;
    we         = 1'b0;
    case (state_q)
      S_INICIAL:       if (jogar) state_d = S_PREPARACAO;
      S_PREPARACAO: begin
        limite_d   = '0;
        endereco_d = '0;
        tempo_d    = '0;
        modo_d     = configuracao[1];
        escrita_d  = configuracao[0];
        state_d    = S_INICIA_RODADA;
      end
      S_INICIA_RODADA: begin
        endereco_d = '0;
        state_d    = S_MOSTRA;
      end
      S_MOSTRA:
        if (cnt_q == SHOW_LAST) state_d = S_INTERVALO;
        else                    cnt_d   = cnt_q + CW'(1);
      S_INTERVALO:
        if (cnt_q == GAP_LAST) state_d = S_TESTA_EXIBICAO;
        else                   cnt_d   = cnt_q + CW'(1);
      S_TESTA_EXIBICAO: state_d = fim_ender ? S_PREP_JOGADA : S_PROXIMO_LED;
      S_PROXIMO_LED: begin
        endereco_d = endereco_q + 4'd1;
        state_d    = S_MOSTRA;
      end
      S_PREP_JOGADA: begin
        endereco_d = '0;
        tempo_d    = '0;
        state_d    = S_ESPERA_JOGADA;
      end
      S_ESPERA_JOGADA, S_ESPERA_ESCRITA: begin
        if (jogada) begin
          jogada_d = botoes;
          state_d  = (state_q == S_ESPERA_JOGADA) ? S_REGISTRA : S_ESCREVE;
        end else if (modo_q && tmo_fim) begin
          state_d = S_FIM_TIMEOUT;
        end else if (!tmo_fim) begin
          tempo_d = tempo_q + 13'd1;
        end
      end
      S_REGISTRA: state_d = S_COMPARA;
      S_COMPARA:
        if (!igual)         state_d = S_PERDEU;
        else if (fim_ender) state_d = S_FIM_RODADA;
        else                state_d = S_PROXIMA_JOGADA;
      S_PROXIMA_JOGADA: begin
        endereco_d = endereco_q + 4'd1;
        tempo_d    = '0;
        state_d    = S_ESPERA_JOGADA;
      end
      S_FIM_RODADA: begin
        tempo_d = '0;
        if (limite_q == 4'd15) state_d = S_GANHOU;
        else if (escrita_q)    state_d = S_ESPERA_ESCRITA;
        else                   state_d = S_PROXIMA_RODADA;
      end
      S_ESCREVE: begin
        we      = escrita_q;
        state_d = S_PROXIMA_RODADA;
      end
      S_PROXIMA_RODADA: begin
        limite_d = limite_q + 4'd1;
        state_d  = S_INICIA_RODADA;
      end
      S_GANHOU, S_PERDEU, S_FIM_TIMEOUT: if (jogar) state_d = S_PREPARACAO;
      default: state_d = S_INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_INICIAL;
      endereco_q <= '0;
      limite_q   <= '0;
      tempo_q    <= '0;
      cnt_q      <= '0;
      jogada_q   <= '0;
      modo_q     <= 1'b0;
      escrita_q  <= 1'b0;
      botao_q    <= 1'b0;
      for (int i = 0; i < 16; i++) mem_q[i] <= PRELOAD[4*i +: 4];
    end else begin
      state_q    <= state_d;
      endereco_q <= endereco_d;
      limite_q   <= limite_d;
      tempo_q    <= tempo_d;
      cnt_q      <= cnt_d;
      jogada_q   <= jogada_d;
      modo_q     <= modo_d;
      escrita_q  <= escrita_d;
      botao_q    <= |botoes;
      if (we) mem_q[limite_q + 4'd1] <= jogada_q;
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign leds     = (state_q == S_MOSTRA) ? mem_rd : 4'b0000;
  assign ganhou   = (state_q == S_GANHOU);
  assign perdeu   = (state_q == S_PERDEU);
  assign timeout  = (state_q == S_FIM_TIMEOUT);
  assign pronto   = ganhou | perdeu | timeout;
  assign leds_rgb = {perdeu | timeout, ganhou | timeout, 1'b0};

  assign db_igual               = igual;
  assign db_enderecoIgualLimite = fim_ender;
  assign db_timeout             = tmo_fim;
  assign db_escrita             = we;
  assign db_clock               = clock;
  assign db_iniciar             = jogar;
  assign db_modo                = modo_q;
  assign db_configuracao        = escrita_q;
  assign db_contagem            = hex7(endereco_q);
  assign db_memoria             = hex7(mem_rd);
  assign db_estado              = hex7(state_q[3:0]);
  assign db_jogadafeita         = hex7(jogada_q);
  assign db_limite_rodada       = hex7(limite_q);

endmodule

`default_nettype wire

// File: tb/tb_jogo_desafio_memoria_top.sv
// tb_jogo_desafio_memoria_top: directed game scenarios against a round/sequence model of the memory game.
// Rev 1.0
`default_nettype none

module tb_jogo_desafio_memoria_top;
  localparam int TO = 40;
  localparam int SH = 6;
  localparam int GP = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       jogar = 1'b0;
  logic [1:0] configuracao = 2'b00;
  logic [3:0] botoes = 4'b0000;
  logic [3:0] leds;
  logic [2:0] leds_rgb;
  logic       ganhou, perdeu, timeout, pronto;
  logic       db_igual, db_enderecoIgualLimite, db_timeout, db_escrita;
  logic       db_clock, db_iniciar, db_modo, db_configuracao;
  logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita, db_limite_rodada;

  jogo_desafio_memoria_top #(.TIMEOUT_CYCLES(TO), .SHOW_CYCLES(SH), .GAP_CYCLES(GP)) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .configuracao(configuracao), .botoes(botoes),
    .leds(leds), .leds_rgb(leds_rgb), .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout),
    .pronto(pronto), .db_igual(db_igual), .db_enderecoIgualLimite(db_enderecoIgualLimite),
    .db_timeout(db_timeout), .db_escrita(db_escrita), .db_clock(db_clock), .db_iniciar(db_iniciar),
    .db_modo(db_modo), .db_configuracao(db_configuracao), .db_contagem(db_contagem),
    .db_memoria(db_memoria), .db_estado(db_estado), .db_jogadafeita(db_jogadafeita),
    .db_limite_rodada(db_limite_rodada)
  );

  always #5 clock = ~clock;

  int         total = 0;
  int         bad   = 0;
  logic [4:0] exp_st   = 5'd0;
  logic [3:0] exp_leds = 4'd0;
  int         exp_res  = 0;   // 0 playing, 1 win, 2 loss, 3 timeout
  bit         chk_en   = 1'b0;
  logic [3:0] mm [16];
  int         lim;
  bit         wmode;

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: seg = 7'b1000000;  4'h1: seg = 7'b1111001;  4'h2: seg = 7'b0100100;  4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;  4'h5: seg = 7'b0010010;  4'h6: seg = 7'b0000010;  4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;  4'h9: seg = 7'b0010000;  4'hA: seg = 7'b0001000;  4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;  4'hD: seg = 7'b0100001;  4'hE: seg = 7'b0000110;  default: seg = 7'b0001110;
    endcase
  endfunction

  function automatic logic [2:0] rgb_of(input int r);
    case (r)
      1: rgb_of = 3'b010;
      2: rgb_of = 3'b100;
      3: rgb_of = 3'b110;
      default: rgb_of = 3'b000;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("leds", 32'(leds), 32'(exp_leds));
      chk("estado", 32'(db_estado), 32'(seg(exp_st[3:0])));
      chk("rgb", 32'(leds_rgb), 32'(rgb_of(exp_res)));
      chk("pronto", 32'(pronto), 32'(exp_res != 0));
      chk("ganhou", 32'(ganhou), 32'(exp_res == 1));
      chk("perdeu", 32'(perdeu), 32'(exp_res == 2));
      chk("timeout", 32'(timeout), 32'(exp_res == 3));
      chk("escrita", 32'(db_escrita), 32'(exp_st == 5'h12));
      chk("iniciar", 32'(db_iniciar), 32'(jogar));
      chk("dbclock", 32'(db_clock), 32'd0);
    end
  end

  task automatic step(input logic [4:0] st, input logic [3:0] l);
    @(posedge clock);
    #1;
    jogar    = 1'b0;
    exp_st   = st;
    exp_leds = l;
  endtask

  task automatic start_game(input logic [1:0] cfg);
    configuracao = cfg;
    jogar = 1'b1;
    step(5'h01, 4'd0);
    exp_res = 0;
    step(5'h02, 4'd0);
    lim   = 0;
    wmode = cfg[0];
  endtask

  task automatic show_round(input int n, input logic [3:0] noise);
    for (int i = 0; i < n; i++) begin
      if (i == 0) botoes = noise;
      repeat (SH) step(5'h03, mm[i]);
      botoes = 4'd0;
      repeat (GP) step(5'h04, 4'd0);
      step(5'h05, 4'd0);
      if (i < n - 1) step(5'h09, 4'd0);
    end
    step(5'h06, 4'd0);
    step(5'h07, 4'd0);
  endtask

  task automatic press(input logic [3:0] v, input int a);
    botoes = v;
    step(5'h08, 4'd0);
    step(5'h0A, 4'd0);
    botoes = 4'd0;
    if (v !== mm[a]) begin
      step(5'h0E, 4'd0);
      exp_res = 2;
    end else if (a == lim) begin
      step(5'h0B, 4'd0);
      if (lim == 15) begin
        step(5'h0D, 4'd0);
        exp_res = 1;
      end else if (wmode) begin
        step(5'h10, 4'd0);
      end else begin
        step(5'h11, 4'd0);
        step(5'h02, 4'd0);
        lim++;
      end
    end else begin
      step(5'h0C, 4'd0);
      step(5'h07, 4'd0);
    end
  endtask

  task automatic write_press(input logic [3:0] v);
    botoes = v;
    step(5'h12, 4'd0);
    botoes = 4'd0;
    step(5'h11, 4'd0);
    mm[lim + 1] = v;
    step(5'h02, 4'd0);
    lim++;
  endtask

  initial begin
    mm[0] = 4'b0001;  mm[1] = 4'b0010;  mm[2] = 4'b0100;  mm[3] = 4'b1000;
    mm[4] = 4'b0100;  mm[5] = 4'b0010;  mm[6] = 4'b0001;  mm[7] = 4'b0001;
    mm[8] = 4'b0010;  mm[9] = 4'b0010;  mm[10] = 4'b0100; mm[11] = 4'b0100;
    mm[12] = 4'b1000; mm[13] = 4'b1000; mm[14] = 4'b0001; mm[15] = 4'b0100;
    #1 reset = 1'b0;
    #1 chk_en = 1'b1;
    repeat (4) step(5'h00, 4'd0);
    reset = 1'b1;
    repeat (2) step(5'h00, 4'd0);
    chk("rst_estado", 32'(db_estado), 32'(7'b1000000));
    chk("rst_contagem", 32'(db_contagem), 32'(7'b1000000));
    chk("rst_leds", 32'(leds), 32'd0);
    chk("rst_rgb", 32'(leds_rgb), 32'd0);
    chk("rst_pronto", 32'(pronto), 32'd0);
    chk("rst_modo", 32'(db_modo), 32'd0);
    chk("rst_jogada", 32'(db_jogadafeita), 32'(7'b1000000));

    // Timeout enabled, nobody plays.
    start_game(2'b10);
    show_round(1, 4'd0);
    repeat (TO - 1) step(5'h07, 4'd0);
    chk("tmo_counter_end", 32'(db_timeout), 32'd1);
    step(5'h0F, 4'd0);
    exp_res = 3;
    chk("tmo_rgb", 32'(leds_rgb), 32'(3'b110));
    chk("tmo_estado", 32'(db_estado), 32'(7'b0001110));
    chk("tmo_modo", 32'(db_modo), 32'd1);
    step(5'h0F, 4'd0);

    // Timeout disabled: long idle, then round 2 lost on its second press.
    start_game(2'b00);
    show_round(1, 4'd0);
    repeat (2 * TO) step(5'h07, 4'd0);
    chk("notmo_modo", 32'(db_modo), 32'd0);
    press(4'b0001, 0);
    show_round(2, 4'd0);
    press(mm[0], 0);
    press(4'b0100, 1);
    chk("loss_rgb", 32'(leds_rgb), 32'(3'b100));
    chk("loss_estado", 32'(db_estado), 32'(7'b0000110));
    chk("loss_jogada", 32'(db_jogadafeita), 32'(7'b0011001));
    chk("loss_igual", 32'(db_igual), 32'd0);
    step(5'h0E, 4'd0);

    // Full 16-round win; stray jogar and an early button press are ignored.
    start_game(2'b00);
    for (int r = 0; r < 16; r++) begin
      if (r == 2) jogar = 1'b1;
      show_round(r + 1, (r == 3) ? 4'b0100 : 4'b0000);
      for (int a = 0; a <= r; a++) press(mm[a], a);
    end
    chk("win_ganhou", 32'(ganhou), 32'd1);
    chk("win_rgb", 32'(leds_rgb), 32'(3'b010));
    chk("win_estado", 32'(db_estado), 32'(7'b0100001));
    chk("win_limite", 32'(db_limite_rodada), 32'(7'b0001110));
    chk("win_igual", 32'(db_igual), 32'd1);
    chk("win_end_eq_lim", 32'(db_enderecoIgualLimite), 32'd1);
    chk("win_memoria", 32'(db_memoria), 32'(7'b0011001));
    step(5'h0D, 4'd0);

    // Write mode: extend the sequence with 1000, then replay it.
    start_game(2'b01);
    show_round(1, 4'd0);
    chk("wr_cfg", 32'(db_configuracao), 32'd1);
    press(4'b0001, 0);
    write_press(4'b1000);
    chk("wr_mem1", 32'(mm[1]), 32'(4'b1000));
    show_round(2, 4'd0);
    press(4'b0001, 0);
    press(4'b1000, 1);
    repeat (3) step(5'h10, 4'd0);

    // Asynchronous reset in the middle of a wait state.
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    chk("async_rst_estado", 32'(db_estado), 32'(7'b1000000));
    chk("async_rst_cfg", 32'(db_configuracao), 32'd0);
    exp_st = 5'h00;
    exp_leds = 4'd0;
    repeat (3) step(5'h00, 4'd0);
    reset = 1'b1;
    repeat (2) step(5'h00, 4'd0);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
